// File: rtl/ysyx_22041461_mem_arbiter_pkg.sv
// Shared state and owner encodings for the ysyx_22041461 memory-port arbiter.
package ysyx_22041461_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle  = 2'd0,
    ArbAddr  = 2'd1,
    ArbWdata = 2'd2,
    ArbResp  = 2'd3
  } arb_state_e;

  // Owner IDs double as the bit index into the {dc, ic} valid vector.
  typedef enum logic {
    ArbIc = 1'b0,
    ArbDc = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/ysyx_22041461_rr_pick.sv
// Two-way round-robin pick: on a tie, grant the requester that did not win last time.
module ysyx_22041461_rr_pick
  import ysyx_22041461_mem_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |valid;
    grant       = ArbIc;
    if (valid == 2'b11) begin
      grant = ~last_grant;
    end else if (valid[ArbDc]) begin
      grant = ArbDc;
    end
  end

endmodule

// File: rtl/ysyx_22041461_mem_arbiter.sv
// Shares one burst memory port between the read-only ICACHE refill path and the
// read/write DCACHE path, one transaction at a time with round-robin arbitration.
module ysyx_22041461_mem_arbiter
  import ysyx_22041461_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ic_req_valid,
  output logic                ic_req_ready,
  input  logic [ADDR_W-1:0]   ic_req_addr,
  input  logic [LEN_W-1:0]    ic_req_len,
  output logic                ic_rsp_valid,
  output logic [DATA_W-1:0]   ic_rsp_data,
  output logic                ic_rsp_last,
  input  logic                dc_req_valid,
  output logic                dc_req_ready,
  input  logic [ADDR_W-1:0]   dc_req_addr,
  input  logic [LEN_W-1:0]    dc_req_len,
  input  logic                dc_req_write,
  input  logic                dc_wdata_valid,
  output logic                dc_wdata_ready,
  input  logic [DATA_W-1:0]   dc_wdata,
  input  logic [DATA_W/8-1:0] dc_wstrb,
  output logic                dc_rsp_valid,
  output logic [DATA_W-1:0]   dc_rsp_data,
  output logic                dc_rsp_last,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [LEN_W-1:0]    mem_req_len,
  output logic                mem_req_write,
  output logic                mem_wdata_valid,
  input  logic                mem_wdata_ready,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_wdata_last,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  input  logic                mem_rsp_last
);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  arb_owner_e        last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              write_q, write_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              pick_grant, pick_valid;

  ysyx_22041461_rr_pick u_rr_pick (
    .valid       ({dc_req_valid, ic_req_valid}),
    .last_grant  (last_grant_q),
    .grant       (pick_grant),
    .grant_valid (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ArbIdle;
      owner_q      <= ArbIc;
      last_grant_q <= ArbIc;
      addr_q       <= '0;
      len_q        <= '0;
      write_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      write_q      <= write_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mem_req_addr  = addr_q;
  assign mem_req_len   = len_q;
  assign mem_req_write = write_q;

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    addr_d          = addr_q;
    len_d           = len_q;
    write_d         = write_q;
    cnt_d           = cnt_q;
    ic_req_ready    = 1'b0;
    dc_req_ready    = 1'b0;
    ic_rsp_valid    = 1'b0;
    ic_rsp_data     = '0;
    ic_rsp_last     = 1'b0;
    dc_rsp_valid    = 1'b0;
    dc_rsp_data     = '0;
    dc_rsp_last     = 1'b0;
    dc_wdata_ready  = 1'b0;
    mem_req_valid   = 1'b0;
    mem_wdata_valid = 1'b0;
    mem_wdata       = '0;
    mem_wstrb       = '0;
    mem_wdata_last  = 1'b0;

    case (state_q)
      ArbIdle: begin
        // Only the picked requester sees ready, so a grant is always a handshake.
        if (pick_valid) begin
          if (pick_grant == ArbDc) begin
            dc_req_ready = 1'b1;
            addr_d       = dc_req_addr;
            len_d        = dc_req_len;
            write_d      = dc_req_write;
          end else begin
            ic_req_ready = 1'b1;
            addr_d       = ic_req_addr;
            len_d        = ic_req_len;
            write_d      = 1'b0;
          end
          owner_d      = arb_owner_e'(pick_grant);
          last_grant_d = arb_owner_e'(pick_grant);
          cnt_d        = '0;
          state_d      = ArbAddr;
        end
      end
      ArbAddr: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = write_q ? ArbWdata : ArbResp;
        end
      end
      ArbWdata: begin
        mem_wdata_valid = dc_wdata_valid;
        dc_wdata_ready  = mem_wdata_ready;
        mem_wdata       = dc_wdata;
        mem_wstrb       = dc_wstrb;
        mem_wdata_last  = (cnt_q == len_q);
        if (dc_wdata_valid && mem_wdata_ready) begin
          if (cnt_q == len_q) begin
            cnt_d   = '0;
            state_d = ArbResp;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      ArbResp: begin
        if (owner_q == ArbDc) begin
          dc_rsp_valid = mem_rsp_valid;
          dc_rsp_data  = mem_rsp_data;
          dc_rsp_last  = mem_rsp_last;
        end else begin
          ic_rsp_valid = mem_rsp_valid;
          ic_rsp_data  = mem_rsp_data;
          ic_rsp_last  = mem_rsp_last;
        end
        if (mem_rsp_valid && mem_rsp_last) begin
          state_d = ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22041461_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized rounds checked against a
// transaction-level round-robin / burst model.
module tb_ysyx_22041461_mem_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned LW = 8;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req_valid, ic_req_ready;
  logic [AW-1:0] ic_req_addr;
  logic [LW-1:0] ic_req_len;
  logic          ic_rsp_valid, ic_rsp_last;
  logic [DW-1:0] ic_rsp_data;
  logic          dc_req_valid, dc_req_ready, dc_req_write;
  logic [AW-1:0] dc_req_addr;
  logic [LW-1:0] dc_req_len;
  logic          dc_wdata_valid, dc_wdata_ready;
  logic [DW-1:0] dc_wdata;
  logic [SW-1:0] dc_wstrb;
  logic          dc_rsp_valid, dc_rsp_last;
  logic [DW-1:0] dc_rsp_data;
  logic          mem_req_valid, mem_req_ready, mem_req_write;
  logic [AW-1:0] mem_req_addr;
  logic [LW-1:0] mem_req_len;
  logic          mem_wdata_valid, mem_wdata_ready, mem_wdata_last;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_rsp_valid, mem_rsp_last;
  logic [DW-1:0] mem_rsp_data;

  always #5 clk = ~clk;

  ysyx_22041461_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_req_len(ic_req_len), .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
    .ic_rsp_last(ic_rsp_last),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
    .dc_req_len(dc_req_len), .dc_req_write(dc_req_write), .dc_wdata_valid(dc_wdata_valid),
    .dc_wdata_ready(dc_wdata_ready), .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb),
    .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data), .dc_rsp_last(dc_rsp_last),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_len(mem_req_len), .mem_req_write(mem_req_write),
    .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wdata_last(mem_wdata_last),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_last(mem_rsp_last)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  endtask

  // Requester-side model: pending requests with stable payloads, plus who won last.
  bit            ic_pend, dc_pend, dc_wr;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [LW-1:0] ic_len, dc_len;
  bit            model_last;  // 0 = IC, 1 = DC
  bit            cur_owner, cur_wr;
  logic [AW-1:0] cur_addr;
  logic [LW-1:0] cur_len;

  function automatic bit model_pick();
    if (ic_pend && dc_pend) return (model_last == 1'b0) ? 1'b1 : 1'b0;
    return dc_pend;
  endfunction

  function automatic logic [63:0] rsp_word(input logic [63:0] a, input int i);
    return {a[31:0], 32'(i + 1) * 32'h11};
  endfunction

  task automatic drive_idle();
    mem_req_ready   = 1'b0;
    mem_wdata_ready = 1'b0;
    mem_rsp_valid   = 1'b0;
    mem_rsp_data    = '0;
    mem_rsp_last    = 1'b0;
    dc_wdata_valid  = 1'b0;
    dc_wdata        = '0;
    dc_wstrb        = '0;
    ic_req_valid    = ic_pend;
    ic_req_addr     = ic_addr;
    ic_req_len      = ic_len;
    dc_req_valid    = dc_pend;
    dc_req_addr     = dc_addr;
    dc_req_len      = dc_len;
    dc_req_write    = dc_wr;
  endtask

  task automatic maybe_spurious();
    if ($urandom_range(0, 2) == 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_last  = 1'($urandom);
      mem_rsp_data  = {$urandom, $urandom};
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq(tag, 64'(|{ic_req_ready, ic_rsp_valid, ic_rsp_data, ic_rsp_last, dc_req_ready,
                        dc_wdata_ready, dc_rsp_valid, dc_rsp_data, dc_rsp_last, mem_req_valid,
                        mem_req_addr, mem_req_len, mem_req_write, mem_wdata_valid, mem_wdata,
                        mem_wstrb, mem_wdata_last}), 64'd0);
  endtask

  task automatic new_ic(input logic [AW-1:0] a, input logic [LW-1:0] l);
    ic_pend = 1'b1; ic_addr = a; ic_len = l;
  endtask

  task automatic new_dc(input logic [AW-1:0] a, input logic [LW-1:0] l, input bit w);
    dc_pend = 1'b1; dc_addr = a; dc_len = l; dc_wr = w;
  endtask

  // One full transaction: grant, address phase, optional write data, response.
  task automatic do_round(input int rst_after, input int req_stall, input bit wstall);
    bit            exp_g;
    int            stall, idx, nb, c;
    logic [DW-1:0] wd;
    logic [SW-1:0] ws;
    logic          own_v, own_l, oth_v;
    logic [DW-1:0] own_d;

    exp_g = model_pick();
    @(negedge clk);
    drive_idle();
    maybe_spurious();
    #1;
    check_eq("grant_ic_ready", 64'(ic_req_ready), 64'(exp_g == 1'b0));
    check_eq("grant_dc_ready", 64'(dc_req_ready), 64'(exp_g == 1'b1));
    check_eq("idle_no_rsp", 64'(ic_rsp_valid | dc_rsp_valid), 64'd0);
    model_last = exp_g;
    cur_owner  = exp_g;
    if (exp_g) begin
      cur_addr = dc_addr; cur_len = dc_len; cur_wr = dc_wr; dc_pend = 1'b0;
    end else begin
      cur_addr = ic_addr; cur_len = ic_len; cur_wr = 1'b0; ic_pend = 1'b0;
    end

    stall = (req_stall >= 0) ? req_stall : int'($urandom_range(0, 3));
    c = 0;
    forever begin
      @(negedge clk);
      drive_idle();
      maybe_spurious();
      mem_req_ready = (c >= stall);
      #1;
      check_eq("mem_req_valid", 64'(mem_req_valid), 64'd1);
      check_eq("mem_req_addr", mem_req_addr, cur_addr);
      check_eq("mem_req_len", 64'(mem_req_len), 64'(cur_len));
      check_eq("mem_req_write", 64'(mem_req_write), 64'(cur_wr));
      check_eq("addr_no_ready", 64'(ic_req_ready | dc_req_ready), 64'd0);
      check_eq("addr_no_rsp", 64'(ic_rsp_valid | dc_rsp_valid), 64'd0);
      if (mem_req_ready) break;
      c++;
    end

    if (cur_wr) begin
      idx = 0; c = 0;
      wd = {$urandom, $urandom};
      ws = SW'($urandom);
      while (idx <= int'(cur_len)) begin
        @(negedge clk);
        drive_idle();
        dc_wdata_valid  = wstall ? 1'b1 : ($urandom_range(0, 3) != 0);
        dc_wdata        = wd;
        dc_wstrb        = ws;
        mem_wdata_ready = wstall ? !(c == 1 || c == 2) : ($urandom_range(0, 3) != 0);
        #1;
        check_eq("wdata_valid_pass", 64'(mem_wdata_valid), 64'(dc_wdata_valid));
        check_eq("wdata_ready_pass", 64'(dc_wdata_ready), 64'(mem_wdata_ready));
        if (dc_wdata_valid && mem_wdata_ready) begin
          check_eq("wdata", mem_wdata, wd);
          check_eq("wstrb", 64'(mem_wstrb), 64'(ws));
          check_eq("wdata_last", 64'(mem_wdata_last), 64'(idx == int'(cur_len)));
          idx++;
          wd = {$urandom, $urandom};
          ws = SW'($urandom);
        end
        c++;
        if (c > 5000) begin
          check_eq("wdata_timeout", 64'(c), 64'd0);
          finish_run();
        end
      end
    end

    nb = cur_wr ? 1 : int'(cur_len) + 1;
    idx = 0;
    while (idx < nb) begin
      @(negedge clk);
      drive_idle();
      mem_rsp_valid = ($urandom_range(0, 3) != 0);
      mem_rsp_data  = cur_wr ? 64'h0ACC : rsp_word(cur_addr, idx);
      mem_rsp_last  = (idx == nb - 1);
      #1;
      own_v = cur_owner ? dc_rsp_valid : ic_rsp_valid;
      own_d = cur_owner ? dc_rsp_data : ic_rsp_data;
      own_l = cur_owner ? dc_rsp_last : ic_rsp_last;
      oth_v = cur_owner ? ic_rsp_valid : dc_rsp_valid;
      check_eq("rsp_valid_owner", 64'(own_v), 64'(mem_rsp_valid));
      check_eq("rsp_valid_other", 64'(oth_v), 64'd0);
      if (mem_rsp_valid) begin
        check_eq("rsp_data", own_d, cur_wr ? 64'h0ACC : rsp_word(cur_addr, idx));
        check_eq("rsp_last", 64'(own_l), 64'(idx == nb - 1));
        idx++;
        if (rst_after >= 0 && idx == rst_after) begin
          @(negedge clk);
          drive_idle();
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          drive_idle();
          #1;
          check_outputs_zero("rst_mid_burst_outs");
          model_last = 1'b0;
          return;
        end
      end
    end
  endtask

  initial begin
    #500_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end

  initial begin
    ic_pend = 0; dc_pend = 0; dc_wr = 0;
    ic_addr = '0; dc_addr = '0; ic_len = '0; dc_len = '0;
    model_last = 1'b0;
    rst = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs_zero("reset_outs");

    // Tie straight after reset goes to DC; IC (read, len 3) follows, then alternation.
    new_ic(64'h8000_0000, 8'd3);
    new_dc(64'h8000_1000, 8'd2, 1'b0);
    do_round(-1, -1, 1'b0);
    do_round(-1, -1, 1'b0);
    new_ic(64'h8000_0040, 8'd0);
    new_dc(64'h8000_2000, 8'd0, 1'b1);
    do_round(-1, -1, 1'b0);
    do_round(-1, -1, 1'b0);

    // Two-beat write with a write-ready stall, then a long address stall.
    new_dc(64'h8000_3000, 8'd1, 1'b1);
    do_round(-1, -1, 1'b1);
    new_dc(64'h8000_4000, 8'd4, 1'b0);
    do_round(-1, 5, 1'b0);

    // Reset after 3 beats of an 8-beat IC refill; DC must be granted right after.
    new_ic(64'h8000_5000, 8'd7);
    do_round(3, -1, 1'b0);
    new_dc(64'h8000_6000, 8'd1, 1'b0);
    do_round(-1, -1, 1'b0);

    // Maximum-length write burst.
    new_dc(64'h8000_7000, 8'd255, 1'b1);
    do_round(-1, 0, 1'b0);

    for (int r = 0; r < 60; r++) begin
      if (!ic_pend && $urandom_range(0, 1) == 1)
        new_ic({$urandom, $urandom} & ~64'h7, LW'($urandom_range(0, 7)));
      if (!dc_pend && $urandom_range(0, 1) == 1)
        new_dc({$urandom, $urandom} & ~64'h7, LW'($urandom_range(0, 7)), 1'($urandom));
      if (!ic_pend && !dc_pend)
        new_dc({$urandom, $urandom} & ~64'h7, LW'($urandom_range(0, 3)), 1'($urandom));
      do_round(-1, -1, 1'b0);
    end

    finish_run();
  end

endmodule

// File: doc/ysyx_22041461_mem_arbiter.md
Name: ysyx_22041461_mem_arbiter

Overview:
- Shares the single external memory port between two requesters: the ICACHE refill path, which is read-only, and the DCACHE/LSU path, which reads and writes.
- Sits below the IF and MEM stages. It grants one transaction at a time and routes the address, write-data and response channels to the granted requester.
- Round-robin on simultaneous requests, so a long DCACHE write stream cannot starve instruction fetch.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, beat data width.
- LEN_W, 8, burst length field; beats = len+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- ic_req_valid  in  1  ICACHE refill request.
- ic_req_ready  out  1  ICACHE request accepted.
- ic_req_addr  in  ADDR_W  ICACHE burst start address.
- ic_req_len  in  LEN_W  ICACHE beats-1.
- ic_rsp_valid  out  1  ICACHE read beat valid.
- ic_rsp_data  out  DATA_W  ICACHE read beat data.
- ic_rsp_last  out  1  ICACHE final beat.
- dc_req_valid  in  1  DCACHE request.
- dc_req_ready  out  1  DCACHE request accepted.
- dc_req_addr  in  ADDR_W  DCACHE burst start address.
- dc_req_len  in  LEN_W  DCACHE beats-1.
- dc_req_write  in  1  1 = write, 0 = read.
- dc_wdata_valid  in  1  DCACHE write beat valid.
- dc_wdata_ready  out  1  DCACHE write beat taken.
- dc_wdata  in  DATA_W  DCACHE write beat data.
- dc_wstrb  in  DATA_W/8  DCACHE byte strobes.
- dc_rsp_valid  out  1  DCACHE read beat, or write ack.
- dc_rsp_data  out  DATA_W  DCACHE response data.
- dc_rsp_last  out  1  DCACHE final beat / write ack.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  memory address.
- mem_req_len  out  LEN_W  memory beats-1.
- mem_req_write  out  1  memory write.
- mem_wdata_valid  out  1  memory write beat valid.
- mem_wdata_ready  in  1  memory takes write beat.
- mem_wdata  out  DATA_W  memory write data.
- mem_wstrb  out  DATA_W/8  memory byte strobes.
- mem_wdata_last  out  1  final write beat.
- mem_rsp_valid  in  1  memory response beat.
- mem_rsp_data  in  DATA_W  memory response data.
- mem_rsp_last  in  1  final response beat / write ack.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0, state=IDLE, last_grant=IC (so the first tie goes to DC), beat counter 0.
- FSM states: IDLE, ADDR, WDATA, RESP.
- IDLE, arbitration:
  - One requester valid: grant it.
  - Both valid: grant the one not equal to last_grant.
  - The granted x_req_ready is combinational, high in IDLE only. It is never high for both requesters in the same cycle.
  - On handshake, latch addr, len, write (IC forces write=0) and owner; update last_grant; go to ADDR.
- ADDR: mem_req_* driven from the latched registers, mem_req_valid=1. On mem_req_ready, go to WDATA if write, else RESP.
  - Minimum latency from req handshake to mem_req_valid: 1 cycle.
- WDATA (DC write only):
  - Pass-through: mem_wdata_valid=dc_wdata_valid, dc_wdata_ready=mem_wdata_ready, data/strb wired through.
  - Counter increments per accepted beat; mem_wdata_last=1 when counter==len.
  - After the last beat is accepted, go to RESP.
- RESP:
  - mem_rsp_valid/data/last are routed combinationally to the owner's rsp_* outputs; the other requester's rsp_valid=0.
  - On mem_rsp_valid & mem_rsp_last, go to IDLE.
  - A write ack is a single beat with last=1.
- Next grant: the new request can be granted in the cycle after the last response, since it waits in IDLE.
- Boundary conditions:
  - mem_rsp_valid outside RESP is dropped and never forwarded.
  - Requests arriving outside IDLE wait, since ready=0; requesters hold valid and payload stable.
  - len=0 gives a single-beat burst; mem_wdata_last is high on the first beat.
  - len=255 gives 256 beats; the counter is LEN_W wide and must not wrap before last.
  - rst asserted mid-burst returns to IDLE immediately and deasserts every output the same edge. The memory side is reset by the same rst.
  - A requester deasserting valid while in IDLE without a handshake loses nothing.

Decomposition:
- Shared macro file ysyx_22041461_macro.v gets:
  - state encodings `ARB_IDLE/`ARB_ADDR/`ARB_WDATA/`ARB_RESP (2 bits);
  - owner IDs `ARB_IC=1'b0, `ARB_DC=1'b1.
- One sub-module: ysyx_22041461_rr_pick (2-way round-robin grant from valid[1:0] and last_grant, combinational).

Test Plan:
- IC only, read, addr 0x8000_0000, len=3, memory returns 4 beats 0x11..0x44 with last on the 4th:
  - ic_rsp_valid pulses 4 times with those data; ic_rsp_last on 0x44; dc_rsp_valid stays 0.
- Simultaneous IC+DC valid after reset:
  - DC granted first (last_grant=IC).
  - After its response completes, IC granted on the next IDLE cycle; last_grant alternates on a repeated tie.
- DC write, len=1, mem_wdata_ready low for 2 cycles mid-burst:
  - Exactly 2 beats forwarded with strobes intact; mem_wdata_last on the 2nd.
  - Single ack produces dc_rsp_valid=1, dc_rsp_last=1.
- mem_req_ready held low 5 cycles:
  - mem_req_addr/len stable, mem_req_valid held.
  - Neither requester's req_ready asserts during the wait.
- rst asserted during RESP of an IC len=7 burst after 3 beats:
  - Next cycle state=IDLE, all outputs 0.
  - A new DC request is granted the cycle after rst deasserts.
- Spurious mem_rsp_valid in IDLE:
  - No rsp_valid on either requester.
